// File: rtl/y_fetch_queue.sv
// Instruction fetch unit: owns the fetch PC, reads imem over req/ack, and buffers
// up to DEPTH {instruction, PC} pairs for decode behind a valid/ready handshake.
module y_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0028
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect,
    input  logic [31:0]                  redirectPC,
    output logic                         imem_req,
    output logic [31:0]                  imem_addr,
    input  logic                         imem_ack,
    input  logic [31:0]                  imem_data,
    output logic [31:0]                  ins,
    output logic [31:0]                  insPC,
    output logic                         insValid,
    input  logic                         insReady,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [31:0]      NOP_INS  = 32'h0000_0013;

    logic [31:0]      r_fetch_pc;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_ins_mem [DEPTH];
    logic [31:0]      r_pc_mem  [DEPTH];

    logic w_push;
    logic w_pop;
    logic w_unused_bits;

    // Request depends only on reset and registered occupancy, never on ack/ready.
    assign imem_req  = !reset && (r_count < FULL_CNT);
    assign imem_addr = r_fetch_pc;
    assign insValid  = (r_count != '0);
    assign count     = r_count;
    assign ins       = insValid ? r_ins_mem[r_head] : NOP_INS;
    assign insPC     = insValid ? r_pc_mem[r_head]  : 32'h0;

    assign w_push = imem_req && imem_ack;
    assign w_pop  = insValid && insReady;

    // Low address bits are forced to zero on redirect.
    assign w_unused_bits = ^redirectPC[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (redirect) begin
            r_fetch_pc <= {redirectPC[31:2], 2'b00};
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_tail     <= r_tail + PTR_W'(1);
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Buffer storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (w_push && !redirect) begin
            r_ins_mem[r_tail] <= imem_data;
            r_pc_mem[r_tail]  <= r_fetch_pc;
        end
    end

endmodule

// File: doc/y_fetch_queue.md
# y_fetch_queue

Instruction fetch unit with a prefetch buffer, sitting directly upstream of decode (`yID`) in the `y*` CPU datapath. It owns the fetch PC and reads instruction memory over a req/ack handshake with variable latency. It buffers up to `DEPTH` instruction/PC pairs and hands them to decode over a valid/ready interface. A redirect input (branch, jump, interrupt entry point) flushes the buffer and restarts fetch at a new address.

## Interface

Parameters:
- `DEPTH`, 4, buffer entries; power of two, ≥2
- `RESET_PC`, 32'h0000_0028, fetch address after reset (default entry point)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `redirect`  in  1  flush buffer and restart fetch at `redirectPC`
- `redirectPC`  in  32  new fetch address; bits [1:0] ignored (forced 0)
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address; always equals internal fetch PC
- `imem_ack`  in  1  memory has `imem_data` for `imem_addr` this cycle
- `imem_data`  in  32  instruction word, valid when `imem_req && imem_ack`
- `ins`  out  32  head instruction; 32'h0000_0013 (NOP) when empty
- `insPC`  out  32  address of head instruction; 0 when empty
- `insValid`  out  1  head entry valid
- `insReady`  in  1  decode accepts head this cycle
- `count`  out  $clog2(DEPTH+1)  current occupancy

## Operation

- State: fetch PC register, circular buffer of `DEPTH` entries {instruction, PC}, head/tail pointers, occupancy `count`.
- `imem_req = !reset && (count < DEPTH)`. It is a function of registered state only; no combinational path from `insReady` or `imem_ack`.
- Fetch transfer occurs on any edge where `imem_req && imem_ack`:
  - push {`imem_data`, `imem_addr`} at tail;
  - fetch PC += 4 (mod 2^32; 0xFFFF_FFFC wraps to 0).
- `imem_addr` is stable while `imem_req` is high and no transfer or redirect occurs. Memory may ack in the first request cycle (zero wait) or any number of cycles later.
- Pop occurs on an edge where `insValid && insReady`. Head advances.
- `insValid = (count != 0)`. `ins`/`insPC` come straight from the head entry, with no extra register stage.
- Push and pop in the same cycle: `count` unchanged; both pointers advance.
- Full (`count == DEPTH`): `imem_req` low, no push. Pop frees a slot and `imem_req` rises the next cycle.
- Empty: pop ignored (`insValid` low). `ins` = NOP, `insPC` = 0.
- Redirect (no reset):
  - `count` ← 0 and pointers ← 0;
  - fetch PC ← {`redirectPC[31:2]`, 2'b00};
  - any transfer or pop in the same cycle is discarded;
  - `insValid` is not gated during the redirect cycle. Decode must ignore what it takes in that cycle.
- Reset: `count` ← 0, pointers ← 0, fetch PC ← `RESET_PC`. Reset has priority over redirect and transfer.
- Reset or redirect asserted mid-request simply abandons that request. Memory reads have no side effects, so no cleanup is needed.
- Pointer wrap: head and tail are `$clog2(DEPTH)` bits and wrap naturally. Full/empty is decided by `count` only.

## Timing

- Reset values:
  - `imem_req` = 0 during the reset cycle, 1 from the first cycle after reset deasserts;
  - `imem_addr` = `RESET_PC`;
  - `insValid` = 0, `ins` = 32'h0000_0013, `insPC` = 0, `count` = 0.
- Fetch latency: ack in cycle N → entry visible (`insValid` = 1) in cycle N+1.
- Throughput with zero-wait memory and `insReady` held high: one instruction per cycle, sustained, and the buffer never fills.
- With `insReady` low, the buffer fills after `DEPTH` transfers and `imem_req` drops in the following cycle.
- Redirect in cycle N:
  - cycle N+1: `imem_addr` = new PC, `insValid` = 0;
  - earliest `insValid` = 1 is cycle N+2 (zero-wait ack in N+1).
- All outputs settle from registered state within the cycle. There are no multicycle paths.

## Test plan

- Reset then zero-wait memory returning addr-as-data, `insReady` = 1 → `imem_addr` sequence 0x28, 0x2C, 0x30…; `insValid` from cycle 2; `ins`/`insPC` = 0x28, 0x2C… one per cycle; `count` ≤ 1.
- `insReady` = 0, zero-wait memory → 4 pushes (0x28–0x34), `count` = 4, `imem_req` low, `imem_addr` held 0x38. Then one pop → `insPC` advances to 0x2C and `imem_req` high the next cycle.
- Memory acks every 3rd cycle → `imem_addr` stable between acks; buffer holds exactly the acked words in order; no duplicates or gaps.
- Redirect to 0x0000_0103 with 3 entries buffered, ack in the same cycle → next cycle `count` = 0, `insValid` = 0, `imem_addr` = 0x100. The acked word is never delivered.
- Fetch PC at 0xFFFF_FFFC → next `imem_addr` = 0x0000_0000.
- Reset and redirect asserted together mid-fill → `imem_addr` = 0x28, `count` = 0 the next cycle.
